// File: rtl/data_ram_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | data_ram_responder: MEM-stage data port responder over a synchronous RAM.   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module data_ram_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        stall_o,
   output logic        ack_o,
   output logic        err_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              we_q;
   logic [31:2]       addr_q;
   logic [3:0]        sel_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic [31:0]       ram [2**ADDR_W];

   logic [ADDR_W-1:0] idx;
   logic              in_range;
   logic              do_access;
   logic              ram_wr;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^mem_addr_i[1:0];

   assign idx       = addr_q[ADDR_W+1:2];
   assign in_range  = (addr_q[31:ADDR_W+2] == '0);
   assign do_access = (state_q == BUSY) && mem_ce_i && (cnt_q == 4'd0);
   // Reset wins over a completing store so an interrupted access never lands.
   assign ram_wr    = do_access && we_q && in_range && !rst;

   always_ff @(posedge clk) begin
      if (ram_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (sel_q[b]) begin
               ram[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         sel_q   <= 4'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mem_ce_i) begin
                  we_q    <= mem_we_i;
                  addr_q  <= mem_addr_i[31:2];
                  sel_q   <= mem_sel_i;
                  wdata_q <= mem_data_i;
                  cnt_q   <= CNT_INIT;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (!mem_ce_i) begin
                  state_q <= IDLE;
               end else if (cnt_q == 4'd0) begin
                  state_q <= ACK;
                  err_q   <= !in_range;
                  rdata_q <= (in_range && !we_q) ? ram[idx] : 32'd0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ACK: begin
               state_q <= IDLE;
               rdata_q <= 32'd0;
               err_q   <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stall_o    = (state_q == IDLE) ? mem_ce_i : (state_q == BUSY);
   assign ack_o      = (state_q == ACK);
   assign mem_data_o = (state_q == ACK) ? rdata_q : 32'd0;
   assign err_o      = (state_q == ACK) && err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_data_ram_responder: directed + random checks against a word-array model. |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_data_ram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce1, ce3, we;
   logic [31:0] addr, wdata;
   logic [3:0]  sel;
   logic [31:0] rd1, rd3;
   logic        st1, st3, ack1, ack3, err1, err3;

   int          dsel;
   int          passed = 0;
   int          total  = 0;
   logic [31:0] mdl [2][1024];
   logic [31:0] last_rd;
   logic        last_err;

   always #5 clk = ~clk;

   data_ram_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .mem_ce_i(ce1), .mem_we_i(we), .mem_addr_i(addr),
      .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rd1), .stall_o(st1),
      .ack_o(ack1), .err_o(err1));

   data_ram_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .mem_ce_i(ce3), .mem_we_i(we), .mem_addr_i(addr),
      .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rd3), .stall_o(st3),
      .ack_o(ack3), .err_o(err3));

   function automatic logic o_ack();   return (dsel != 0) ? ack3 : ack1; endfunction
   function automatic logic o_stall(); return (dsel != 0) ? st3  : st1;  endfunction
   function automatic logic o_err();   return (dsel != 0) ? err3 : err1; endfunction
   function automatic logic [31:0] o_data(); return (dsel != 0) ? rd3 : rd1; endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic set_ce(input int d, input logic v);
      if (d != 0) ce3 = v;
      else        ce1 = v;
   endtask

   // Reference: a word array indexed by addr/4, big-endian lanes, 4 KiB window.
   task automatic model(input int d, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] v,
                        output logic [31:0] ed, output logic ee);
      int unsigned word;
      logic [31:0] cur;
      ed = 32'd0;
      ee = 1'b0;
      if (a >= 32'h0000_1000) begin
         ee = 1'b1;
      end else begin
         word = a / 4;
         cur  = mdl[d][word];
         if (w) begin
            if (s[3]) cur[31:24] = v[31:24];
            if (s[2]) cur[23:16] = v[23:16];
            if (s[1]) cur[15:8]  = v[15:8];
            if (s[0]) cur[7:0]   = v[7:0];
            mdl[d][word] = cur;
         end else begin
            ed = cur;
         end
      end
   endtask

   task automatic access(input int d, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] v, input bit keep);
      int          wc;
      int          k;
      int          stall_n;
      bit          got;
      logic [31:0] ed;
      logic        ee;
      wc = (d != 0) ? 3 : 1;
      model(d, w, a, s, v, ed, ee);
      dsel = d;
      we = w; addr = a; sel = s; wdata = v;
      set_ce(d, 1'b1);
      got = 0; k = 0; stall_n = 0;
      while (!got && k < 40) begin
         #1;
         if (o_ack()) begin
            got = 1;
         end else begin
            if (o_stall()) stall_n++;
            k++;
            @(negedge clk);
            we    = 1'($urandom_range(0, 1));
            addr  = $urandom;
            sel   = 4'($urandom);
            wdata = $urandom;
         end
      end
      chk("ack_seen", 32'(got), 32'd1);
      chk("ack_latency", k, wc + 2);
      chk("stall_cycles", stall_n, wc + 2);
      chk("stall_in_ack", 32'(o_stall()), 32'd0);
      chk("rdata", o_data(), ed);
      chk("err", 32'(o_err()), 32'(ee));
      last_rd  = o_data();
      last_err = o_err();
      @(negedge clk);
      if (!keep) set_ce(d, 1'b0);
      #1;
      chk("ack_single", 32'(o_ack()), 32'd0);
      chk("idle_stall", 32'(o_stall()), keep ? 32'd1 : 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  d;
      bit  kp;
      bit  seen;
      rst = 1'b1; ce1 = 1'b0; ce3 = 1'b0; we = 1'b0;
      addr = 32'd0; sel = 4'd0; wdata = 32'd0; dsel = 0;
      last_rd = 32'd0; last_err = 1'b0;

      // Reset state, with request valid held during reset.
      repeat (2) @(negedge clk);
      ce1 = 1'b1; ce3 = 1'b1;
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         dsel = i;
         chk("rst_ack", 32'(o_ack()), 32'd0);
         chk("rst_err", 32'(o_err()), 32'd0);
         chk("rst_data", o_data(), 32'd0);
         chk("rst_stall_ce1", 32'(o_stall()), 32'd1);
      end
      ce1 = 1'b0; ce3 = 1'b0;
      #1;
      chk("rst_stall_ce0", 32'(st1), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 16; j++)
            access(i, 1'b1, 32'(j * 4), 4'hF, $urandom, 0);

      // Word store/load.
      access(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0);
      access(0, 1'b0, 32'h10, 4'hF, 32'h0, 0);
      chk("word_load", last_rd, 32'hDEADBEEF);

      // Byte lanes.
      access(0, 1'b1, 32'h10, 4'hF, 32'h11223344, 0);
      access(0, 1'b1, 32'h10, 4'b0100, 32'hAAAAAAAA, 0);
      access(0, 1'b0, 32'h10, 4'h0, 32'h0, 0);
      chk("lane_one", last_rd, 32'h11AA3344);
      access(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 0);
      access(0, 1'b0, 32'h10, 4'hF, 32'h0, 0);
      chk("lane_none", last_rd, 32'h11AA3344);
      access(0, 1'b1, 32'h10, 4'b0011, 32'h55665566, 0);
      access(0, 1'b0, 32'h10, 4'hF, 32'h0, 0);
      chk("lane_low", last_rd, 32'h11AA5566);

      // Out of range must not alias onto word 0.
      access(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 0);
      access(0, 1'b1, 32'h1000, 4'hF, 32'h99999999, 0);
      chk("oor_store_err", 32'(last_err), 32'd1);
      access(0, 1'b0, 32'h0, 4'hF, 32'h0, 0);
      chk("oor_no_alias", last_rd, 32'hCAFEF00D);
      access(0, 1'b0, 32'h1000, 4'hF, 32'h0, 0);
      chk("oor_load_data", last_rd, 32'h0);
      chk("oor_load_err", 32'(last_err), 32'd1);

      // Abort in first BUSY cycle.
      access(0, 1'b1, 32'h20, 4'hF, 32'h0BADF00D, 0);
      dsel = 0;
      we = 1'b1; addr = 32'h20; sel = 4'hF; wdata = 32'h12345678; ce1 = 1'b1;
      @(negedge clk);
      #1;
      chk("abort_busy_stall", 32'(st1), 32'd1);
      ce1 = 1'b0;
      @(negedge clk);
      #1;
      chk("abort_idle_stall", 32'(st1), 32'd0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (ack1) seen = 1;
         @(negedge clk);
         #1;
      end
      chk("abort_no_ack", 32'(seen), 32'd0);
      access(0, 1'b0, 32'h20, 4'hF, 32'h0, 0);
      chk("abort_no_write", last_rd, 32'h0BADF00D);

      // Reset in second BUSY cycle, WAIT_CYCLES=3.
      access(1, 1'b1, 32'h40, 4'hF, 32'h01020304, 0);
      dsel = 1;
      we = 1'b1; addr = 32'h40; sel = 4'hF; wdata = 32'hFFFF0000; ce3 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; ce3 = 1'b0;
      #1;
      chk("rstb_ack", 32'(ack3), 32'd0);
      chk("rstb_err", 32'(err3), 32'd0);
      chk("rstb_data", rd3, 32'd0);
      chk("rstb_stall", 32'(st3), 32'd0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (ack3) seen = 1;
         @(negedge clk);
         #1;
      end
      chk("rstb_no_ack", 32'(seen), 32'd0);
      access(1, 1'b0, 32'h40, 4'hF, 32'h0, 0);
      chk("rstb_no_write", last_rd, 32'h01020304);
      access(1, 1'b1, 32'h44, 4'hF, 32'h76543210, 0);
      access(1, 1'b0, 32'h44, 4'hF, 32'h0, 0);
      chk("rstb_recover", last_rd, 32'h76543210);

      // Back-to-back loads, mem_ce_i held high across the ACK.
      access(0, 1'b0, 32'h10, 4'hF, 32'h0, 1);
      chk("b2b_first", last_rd, 32'h11AA5566);
      access(0, 1'b0, 32'h0, 4'hF, 32'h0, 0);
      chk("b2b_second", last_rd, 32'hCAFEF00D);

      // Randomized traffic.
      d  = 0;
      kp = 0;
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         if (!kp) d = int'($urandom_range(0, 1));
         a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 1023)) << 12);
         kp = ($urandom_range(0, 2) == 0);
         access(d, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, kp);
      end
      access(d, 1'b0, 32'h0, 4'hF, 32'h0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
